rank_select: RTL and testbench



---
 rtl/rof_pkg.sv | 18 +
 rtl/rank_match_mux.sv | 41 ++++
 rtl/rank_select.sv | 105 ++++++++++
 tb/tb_rank_select.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rof_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rof_pkg
// Purpose  : Shared constants and helpers for the masked rank-order filter.
// Revision : 1.0 - initial release
// ============================================================================
package rof_pkg;

  localparam int ROF_N      = 7;
  localparam int ROF_DATA_W = 8;

  // Width needed to hold a rank 0..n.
  function automatic int rank_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rank_match_mux.sv
`default_nettype none
// ============================================================================
// Module   : rank_match_mux
// Purpose  : Combinational rank match and lowest-index sample select.
// Revision : 1.0 - initial release
// ============================================================================
module rank_match_mux #(
  parameter int N      = 7,
  parameter int DATA_W = 8,
  parameter int RANK_W = 3
) (
  input  logic [RANK_W*N-1:0] ranks,
  input  logic [N-1:0]        mask,
  input  logic [RANK_W-1:0]   k,
  input  logic [DATA_W*N-1:0] win,
  output logic [N-1:0]        hit,
  output logic [DATA_W-1:0]   sel_sample,
  output logic                miss
);

  logic w_found;

  always_comb begin
    hit        = '0;
    sel_sample = '0;
    w_found    = 1'b0;
    for (int j = 0; j < N; j++) begin
      hit[j] = mask[j] && (ranks[j*RANK_W +: RANK_W] == k);
    end
    // Duplicate ranks only arise from an upstream fault; lowest slot wins.
    for (int j = 0; j < N; j++) begin
      if (hit[j] && !w_found) begin
        sel_sample = win[j*DATA_W +: DATA_W];
        w_found    = 1'b1;
      end
    end
    miss = ~|hit;
  end

endmodule
`default_nettype wire

// File: rtl/rank_select.sv
`default_nettype none
// ============================================================================
// Module   : rank_select
// Purpose  : Output stage of the masked rank-order filter; selects the k-th
//            order statistic from the sliding window. Optional macro
//            RANK_SELECT_ERR_EN adds a sticky duplicate-rank error output.
// Revision : 1.0 - initial release
// ============================================================================
module rank_select
  import rof_pkg::*;
#(
  parameter int  N      = ROF_N,
  parameter int  DATA_W = ROF_DATA_W,
  localparam int RANK_W = rank_bits(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_sample,
  input  logic [RANK_W*N-1:0] ranks,
  input  logic [N-1:0]        mask,
  input  logic [RANK_W-1:0]   k,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_sample,
  output logic                out_miss
`ifdef RANK_SELECT_ERR_EN
  ,
  output logic                err
`endif
);

  localparam logic [RANK_W-1:0] C_FULL = RANK_W'(N);
  localparam logic [RANK_W-1:0] C_ONE  = RANK_W'(1);

  logic [DATA_W*N-1:0] r_win;
  logic [N-1:0]        r_vtag;
  logic [RANK_W-1:0]   r_fill;
  logic [N-1:0]        w_hit;
  logic [DATA_W-1:0]   w_sel;
  logic                w_miss;

  rank_match_mux #(
    .N      (N),
    .DATA_W (DATA_W),
    .RANK_W (RANK_W)
  ) u_match (
    .ranks      (ranks),
    .mask       (mask),
    .k          (k),
    .win        (r_win),
    .hit        (w_hit),
    .sel_sample (w_sel),
    .miss       (w_miss)
  );

  // Slot N-1 holds the newest sample, matching the rank register order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win      <= '0;
      r_vtag     <= '0;
      r_fill     <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_miss   <= 1'b0;
    end else begin
      r_win  <= {in_sample, r_win[DATA_W*N-1:DATA_W]};
      r_vtag <= {in_valid, r_vtag[N-1:1]};
      if (!in_valid) begin
        r_fill <= '0;
      end else if (r_fill != C_FULL) begin
        r_fill <= r_fill + C_ONE;
      end
      out_sample <= w_sel;
      out_miss   <= w_miss;
      out_valid  <= (r_fill == C_FULL) && r_vtag[0];
    end
  end

`ifdef RANK_SELECT_ERR_EN
  logic [RANK_W-1:0] w_hit_cnt;
  logic [RANK_W-1:0] r_hit_cnt;
  logic              r_full;

  always_comb begin
    w_hit_cnt = '0;
    for (int j = 0; j < N; j++) begin
      w_hit_cnt = w_hit_cnt + {{(RANK_W-1){1'b0}}, w_hit[j]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt <= '0;
      r_full    <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_hit_cnt <= w_hit_cnt;
      r_full    <= (r_fill == C_FULL);
      err       <= err | (r_full && (|r_hit_cnt[RANK_W-1:1]));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rank_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_rank_select
// Purpose  : Scoreboard bench for rank_select (N=7, DATA_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rank_select;

  localparam int N  = 7;
  localparam int DW = 8;
  localparam int RW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_sample;
  logic [RW*N-1:0] ranks;
  logic [N-1:0]    mask;
  logic [RW-1:0]   k;
  logic            out_valid;
  logic [DW-1:0]   out_sample;
  logic            out_miss;
  logic            err;

  always #5 clk = ~clk;

  rank_select dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .ranks      (ranks),
    .mask       (mask),
    .k          (k),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .out_miss   (out_miss)
`ifdef RANK_SELECT_ERR_EN
    ,
    .err        (err)
`endif
  );

`ifndef RANK_SELECT_ERR_EN
  assign err = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [7:0]  s;
    logic        m;
    logic        e;
    logic [63:0] nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] p[7] = '{8'd10, 8'd50, 8'd30, 8'd70, 8'd20, 8'd60, 8'd40};
  logic [7:0] mt[6] = '{7'b1010101, 7'b0111000, 7'h7F, 7'b1100011, 7'b0001111, 7'b1111110};
  logic [2:0] kt[6] = '{3'd2, 3'd3, 3'd7, 3'd1, 3'd4, 3'd6};

  // Reference window and state
  logic [7:0] m_win[7];
  logic [6:0] m_vtag;
  int         m_fill;
  logic       m_err;
  logic       m_dup_prev;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_win[i] = 8'd0;
    m_vtag = '0; m_fill = 0; m_err = 1'b0; m_dup_prev = 1'b0;
  endtask

  // Stand-in for masked_ranks: distinct ranks 1..M over masked-in slots.
  function automatic logic [RW*N-1:0] gen_ranks(input logic [6:0] m);
    logic [RW*N-1:0] r;
    int c;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if (m[j]) begin
        c = 1;
        for (int i = 0; i < N; i++)
          if (m[i] && (m_win[i] < m_win[j] || (m_win[i] == m_win[j] && i < j))) c++;
        r[j*RW +: RW] = 3'(c);
      end
    end
    return r;
  endfunction

  // Expected order statistic by sorting the masked-in samples.
  task automatic model_sel(input logic [6:0] m, input logic [2:0] kk,
                           output logic [7:0] s, output logic ms);
    logic [7:0] v[7];
    logic [7:0] t;
    int cnt;
    cnt = 0;
    for (int j = 0; j < N; j++) if (m[j]) begin v[cnt] = m_win[j]; cnt++; end
    for (int i = 0; i < cnt; i++)
      for (int j = 0; j < cnt - 1 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    if (kk == 3'd0 || int'(kk) > cnt) begin s = 8'd0; ms = 1'b1; end
    else begin s = v[int'(kk)-1]; ms = 1'b0; end
  endtask

  task automatic step(input logic v, input logic [7:0] smp, input logic [6:0] m,
                      input logic [2:0] kk, input logic hand, input logic hv,
                      input logic [7:0] hs, input logic hm, input logic dup,
                      input logic [63:0] nm);
    exp_t e;
    logic [RW*N-1:0] r;
    @(negedge clk);
    r = gen_ranks(m);
    if (dup) begin r[2*RW +: RW] = 3'd4; r[5*RW +: RW] = 3'd4; end
    in_valid = v; in_sample = smp; mask = m; k = kk; ranks = r;
    if (hand) begin
      e.v = hv; e.s = hs; e.m = hm;
    end else begin
      e.v = (m_fill == N) && m_vtag[0];
      model_sel(m, kk, e.s, e.m);
    end
    m_err = m_err | m_dup_prev;
    e.e = m_err;
    m_dup_prev = dup && (m_fill == N);
    e.nm = nm;
    q.push_back(e);
    for (int i = 0; i < N-1; i++) m_win[i] = m_win[i+1];
    m_win[N-1] = smp;
    m_vtag = {v, m_vtag[6:1]};
    m_fill = v ? ((m_fill < N) ? m_fill + 1 : N) : 0;
  endtask

  task automatic check_zero(input logic [63:0] nm);
    n_cmp++;
    if (out_valid !== 1'b0 || out_sample !== 8'd0 || out_miss !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %0s: got v=%b s=%0d m=%b e=%b, want all 0", nm, out_valid, out_sample, out_miss, err);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0; in_sample = 8'd0;
    #1 check_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every step yields exactly one result one edge later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (out_valid !== e.v || (e.v && (out_sample !== e.s || out_miss !== e.m))) begin
          n_bad++;
          $display("FAIL %0s: got v=%b s=%0d m=%b, want v=%b s=%0d m=%b",
                   e.nm, out_valid, out_sample, out_miss, e.v, e.s, e.m);
        end
`ifdef RANK_SELECT_ERR_EN
        n_cmp++;
        if (err !== e.e) begin
          n_bad++;
          $display("FAIL %0s_err: got err=%b, want %b", e.nm, err, e.e);
        end
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; ranks = '0; mask = '0; k = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("rst_init");
    rst = 1'b0;

    for (int s = 0; s < 7; s++) step(1, p[s%7], 7'h7F, 3'd4, 0, 0, 0, 0, 0, "fill");
    step(1, p[0], 7'h7F, 3'd4, 1, 1, 8'd40, 0, 0, "median");
    for (int s = 8; s < 14; s++) step(1, p[s%7], mt[s-8][6:0], kt[s-8], 0, 0, 0, 0, 0, "mix_a");
    step(1, p[0], 7'b0000111, 3'd1, 1, 1, 8'd10, 0, 0, "wmask_k1");
    for (int s = 15; s < 21; s++) step(1, p[s%7], mt[s-15][6:0], kt[s-15], 0, 0, 0, 0, 0, "mix_b");
    step(1, p[0], 7'b0000111, 3'd3, 1, 1, 8'd50, 0, 0, "wmask_k3");
    step(1, p[1], 7'h7F, 3'd0, 1, 1, 8'd0, 1, 0, "k_zero");
    step(1, p[2], 7'h3F, 3'd7, 1, 1, 8'd0, 1, 0, "k_gt_m");
    step(1, p[3], 7'h00, 3'd3, 1, 1, 8'd0, 1, 0, "mask0");
    // Gap at s=25
    step(0, p[4], 7'h7F, 3'd4, 0, 0, 0, 0, 0, "gap");
    step(1, p[5], 7'h7F, 3'd4, 1, 0, 8'd0, 0, 0, "gap_next");
    for (int s = 27; s < 32; s++) step(1, p[s%7], 7'h7F, 3'd4, 0, 0, 0, 0, 0, "refill");
    step(1, p[4], 7'h7F, 3'd4, 1, 0, 8'd0, 0, 0, "refill6");
    step(1, p[5], 7'h7F, 3'd4, 1, 1, 8'd40, 0, 0, "refill7");
    for (int s = 34; s < 36; s++) step(1, p[s%7], 7'b1100011, 3'd2, 0, 0, 0, 0, 0, "post");

    do_reset();
    for (int t = 0; t < 6; t++) step(1, p[t], 7'h7F, 3'd4, 0, 0, 0, 0, 0, "rfill");
    step(1, p[6], 7'h7F, 3'd4, 1, 0, 8'd0, 0, 0, "rfill6");
    step(1, p[0], 7'h7F, 3'd4, 1, 1, 8'd40, 0, 0, "rfill7");
    step(1, p[1], 7'h7F, 3'd4, 1, 1, 8'd70, 0, 1, "dup_rank");
    for (int t = 9; t < 13; t++) step(1, p[t%7], 7'h7F, 3'd4, 0, 0, 0, 0, 0, "after_dup");

    do_reset();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending results, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
